mul_exec_stage: RTL and testbench

Execute-stage wrapper that accepts multiply operands from decode/issue under a valid/ready handshake and feeds them, registered, into the combinational 32x32 signed tree multiplier (mul_tree32). The block then pipelines the 32-bit product through LAT result registers toward the writeback mux. Destination-register tags travel alongside each product. The pipeline supports backpressure, bubble collapsing and pipeline flush.

---
 rtl/mul_exec_stage_pkg.sv | 14 +
 rtl/mul_exec_stage_if.sv | 29 ++
 rtl/mul_tree32.sv | 26 ++
 rtl/mul_exec_stage.sv | 107 ++++++++++
 tb/tb_mul_exec_stage.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mul_exec_stage_pkg.sv
// Shared constants for the multiply execute stage. Issue and writeback import
// the same tag width so destination tags line up across the pipeline.
package mul_exec_stage_pkg;

  localparam int unsigned MUL_LAT_MIN = 1;
  localparam int unsigned MUL_LAT_MAX = 4;
  localparam int unsigned MUL_TAG_W   = 4;

  // True when a result-register depth is supported by the stage.
  function automatic bit mul_lat_legal(input int unsigned lat);
    return (lat >= MUL_LAT_MIN) && (lat <= MUL_LAT_MAX);
  endfunction

endpackage

// File: rtl/mul_exec_stage_if.sv
// Issue-side operand channel and writeback-side result channel of the
// multiply execute stage, both valid/ready handshakes.
interface mul_exec_stage_if
  import mul_exec_stage_pkg::*;
#(
  parameter int unsigned TAG_W = MUL_TAG_W
);
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_a;
  logic [31:0]      in_b;
  logic [TAG_W-1:0] in_rd;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_result;
  logic [TAG_W-1:0] out_rd;

  // Issue/writeback side: drives operands and result acceptance.
  modport master (
    output in_valid, in_a, in_b, in_rd, out_ready,
    input  in_ready, out_valid, out_result, out_rd
  );

  // Execute stage side.
  modport slave (
    input  in_valid, in_a, in_b, in_rd, out_ready,
    output in_ready, out_valid, out_result, out_rd
  );
endinterface

// File: rtl/mul_tree32.sv
// Combinational 32x32 multiplier, adder-tree reduction of partial products.
// Only the low 32 bits of the product are produced; those bits are identical
// for signed and unsigned operands, so no sign correction is needed.
module mul_tree32 (
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output logic [31:0] o_p
);

  for (genvar l = 0; l <= 5; l++) begin : g_lvl
    localparam int unsigned N = 32 >> l;
    logic [31:0] w_s [N];
    if (l == 0) begin : g_pp
      for (genvar k = 0; k < 32; k++) begin : g_row
        assign w_s[k] = i_b[k] ? (i_a << k) : '0;
      end
    end else begin : g_add
      for (genvar k = 0; k < N; k++) begin : g_sum
        assign w_s[k] = g_lvl[l-1].w_s[2*k] + g_lvl[l-1].w_s[2*k+1];
      end
    end
  end

  assign o_p = g_lvl[5].w_s[0];

endmodule

// File: rtl/mul_exec_stage.sv
// Multiply execute stage: registered operand slot feeding mul_tree32,
// followed by LAT result slots carrying {product, rd} toward writeback.
// Every slot advances independently, so bubbles collapse under stall.
module mul_exec_stage
  import mul_exec_stage_pkg::*;
#(
  parameter int unsigned LAT   = 2,
  parameter int unsigned TAG_W = MUL_TAG_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  mul_exec_stage_if.slave  bus,
  output logic             busy
);

  if (!mul_lat_legal(LAT)) begin : g_lat_chk
    $error("mul_exec_stage: LAT=%0d outside %0d..%0d", LAT, MUL_LAT_MIN, MUL_LAT_MAX);
  end

  logic [LAT:0]     r_vld;
  logic [LAT:0]     w_adv;
  logic [31:0]      r_a;
  logic [31:0]      r_b;
  logic [TAG_W-1:0] r_rd0;
  logic [31:0]      w_prod;
  logic             w_in_ready;
  logic             w_acc;

  // Advance chain, resolved from the output slot back toward slot0.
  always_comb begin
    w_adv      = '0;
    w_adv[LAT] = r_vld[LAT] & bus.out_ready;
    for (int unsigned k = 1; k <= LAT; k++) begin
      w_adv[LAT-k] = r_vld[LAT-k] & (~r_vld[LAT-k+1] | w_adv[LAT-k+1]);
    end
  end

  assign w_in_ready = ~flush & (~r_vld[0] | w_adv[0]);
  assign w_acc      = bus.in_valid & w_in_ready;

  // Slot occupancy: fill from predecessor, empty on advance, clear on flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld <= '0;
    end else if (flush) begin
      r_vld <= '0;
    end else begin
      r_vld[0] <= w_acc | (r_vld[0] & ~w_adv[0]);
      for (int unsigned k = 1; k <= LAT; k++) begin
        r_vld[k] <= w_adv[k-1] | (r_vld[k] & ~w_adv[k]);
      end
    end
  end

  // Operand slot, loaded only on an accepted handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a   <= '0;
      r_b   <= '0;
      r_rd0 <= '0;
    end else if (w_acc) begin
      r_a   <= bus.in_a;
      r_b   <= bus.in_b;
      r_rd0 <= bus.in_rd;
    end
  end

  mul_tree32 u_mul (
    .i_a (r_a),
    .i_b (r_b),
    .o_p (w_prod)
  );

  for (genvar g = 1; g <= LAT; g++) begin : g_slot
    logic [31:0]      r_res;
    logic [TAG_W-1:0] r_rd;
    logic [31:0]      w_d_res;
    logic [TAG_W-1:0] w_d_rd;

    if (g == 1) begin : g_from_mul
      assign w_d_res = w_prod;
      assign w_d_rd  = r_rd0;
    end else begin : g_from_prev
      assign w_d_res = g_slot[g-1].r_res;
      assign w_d_rd  = g_slot[g-1].r_rd;
    end

    // Result slot data, loaded only when the predecessor advances into it.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_res <= '0;
        r_rd  <= '0;
      end else if (w_adv[g-1]) begin
        r_res <= w_d_res;
        r_rd  <= w_d_rd;
      end
    end
  end

  assign bus.in_ready   = w_in_ready;
  assign bus.out_valid  = r_vld[LAT];
  assign bus.out_result = g_slot[LAT].r_res;
  assign bus.out_rd     = g_slot[LAT].r_rd;
  assign busy           = |r_vld;

endmodule

// File: tb/tb_mul_exec_stage.sv
// Directed bench for mul_exec_stage with LAT=2, TAG_W=4.
module tb_mul_exec_stage;

  typedef struct packed {
    logic [31:0] res;
    logic [3:0]  rd;
  } exp_t;

  logic clk;
  logic rst_n;
  logic flush;
  logic w_busy;

  mul_exec_stage_if #(.TAG_W(4)) bus ();

  mul_exec_stage #(.LAT(2), .TAG_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus),
    .busy  (w_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_vec   = 0;
  int   n_miss  = 0;
  int   cyc_n   = 0;
  int   n_out   = 0;
  int   n_stall = 0;
  int   last_out = 0;
  int   acc_cyc  = 0;
  exp_t exp_q[$];

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200000");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // One clock cycle: sample at negedge, score any output handshake, end at posedge+1.
  task automatic cyc(output bit acc);
    exp_t e;
    @(negedge clk);
    cyc_n++;
    acc = bus.in_valid && bus.in_ready;
    if (bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        chk("spurious_out", 32'(bus.out_valid), 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("result", bus.out_result, e.res);
        chk("rd", 32'(bus.out_rd), 32'(e.rd));
        n_out++;
        last_out = cyc_n;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic push_op(input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] rd, input logic [31:0] res);
    bit acc;
    acc          = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_rd    = rd;
    for (int k = 0; k < 50 && !acc; k++) begin
      cyc(acc);
      if (!acc) n_stall++;
    end
    if (acc) begin
      exp_q.push_back('{res: res, rd: rd});
      acc_cyc = cyc_n;
    end else begin
      chk("accept_timeout", 32'(bus.in_ready), 32'd1);
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    bit acc;
    for (int k = 0; k < 60 && (exp_q.size() != 0 || w_busy); k++) cyc(acc);
    chk("drain_q", 32'(exp_q.size()), 32'd0);
    chk("drain_busy", 32'(w_busy), 32'd0);
  endtask

  logic [31:0] bp_a  [5] = '{32'd2, 32'hFFFFFFFC, 32'd100, 32'h40000000, 32'd5};
  logic [31:0] bp_b  [5] = '{32'd3, 32'd4, 32'hFFFFFFFF, 32'd4, 32'd5};
  logic [31:0] bp_r  [5] = '{32'd6, 32'hFFFFFFF0, 32'hFFFFFF9C, 32'd0, 32'd25};
  logic [3:0]  bp_rd [5] = '{4'd9, 4'd10, 4'd11, 4'd12, 4'd13};

  initial begin
    bit acc;
    int j;
    int mark;
    int a0;

    rst_n         = 1'b0;
    flush         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_rd     = '0;
    bus.out_ready = 1'b1;

    // Reset state
    #3;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_busy", 32'(w_busy), 32'd0);
    chk("rst_out_result", bus.out_result, 32'd0);
    chk("rst_out_rd", 32'(bus.out_rd), 32'd0);
    #10 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);

    // Basic: 7 * -3, rd 5, result visible LAT+1 cycles after presentation
    bus.in_valid = 1'b1;
    bus.in_a     = 32'd7;
    bus.in_b     = 32'hFFFFFFFD;
    bus.in_rd    = 4'd5;
    #1;
    chk("basic_in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    chk("basic_ov_c1", 32'(bus.out_valid), 32'd0);
    @(posedge clk); #1;
    chk("basic_ov_c2", 32'(bus.out_valid), 32'd0);
    @(posedge clk); #1;
    chk("basic_ov_c3", 32'(bus.out_valid), 32'd1);
    chk("basic_result", bus.out_result, 32'hFFFFFFEB);
    chk("basic_rd", 32'(bus.out_rd), 32'd5);
    @(posedge clk); #1;
    chk("basic_ov_c4", 32'(bus.out_valid), 32'd0);
    chk("basic_busy", 32'(w_busy), 32'd0);

    // Corner values
    push_op(32'h80000000, 32'hFFFFFFFF, 4'd1, 32'h80000000);
    push_op(32'h7FFFFFFF, 32'h7FFFFFFF, 4'd2, 32'h00000001);
    push_op(32'hFFFFFFFF, 32'hFFFFFFFF, 4'd3, 32'h00000001);
    push_op(32'h00000000, 32'h12345678, 4'd4, 32'h00000000);
    drain();

    // Back-to-back 8 ops, rd 0..7
    n_stall = 0;
    mark    = n_out;
    push_op(32'd3,        32'd5,        4'd0, 32'h0000000F);
    a0 = acc_cyc;
    push_op(32'hFFFFFFFE, 32'd6,        4'd1, 32'hFFFFFFF4);
    push_op(32'h00010000, 32'h00010000, 4'd2, 32'h00000000);
    push_op(32'h12345678, 32'd1,        4'd3, 32'h12345678);
    push_op(32'hFFFFFFF9, 32'hFFFFFFF7, 4'd4, 32'h0000003F);
    push_op(32'h7FFFFFFF, 32'd2,        4'd5, 32'hFFFFFFFE);
    push_op(32'd1000,     32'd1000,     4'd6, 32'h000F4240);
    push_op(32'h0000FFFF, 32'h0000FFFF, 4'd7, 32'hFFFE0001);
    chk("b2b_accept_span", 32'(acc_cyc - a0), 32'd7);
    drain();
    chk("b2b_stalls", 32'(n_stall), 32'd0);
    chk("b2b_count", 32'(n_out - mark), 32'd8);
    chk("b2b_last_lat", 32'(last_out - acc_cyc), 32'd3);

    // Backpressure: out_ready low for 10 cycles while streaming
    bus.out_ready = 1'b0;
    j = 0;
    for (int c = 0; c < 10; c++) begin
      if (j < 5) begin
        bus.in_valid = 1'b1;
        bus.in_a     = bp_a[j];
        bus.in_b     = bp_b[j];
        bus.in_rd    = bp_rd[j];
      end else begin
        bus.in_valid = 1'b0;
      end
      cyc(acc);
      if (acc) begin
        exp_q.push_back('{res: bp_r[j], rd: bp_rd[j]});
        j++;
      end
      if (bus.out_valid) chk("bp_held", bus.out_result, 32'd6);
    end
    bus.in_valid = 1'b0;
    chk("bp_accepts", 32'(j), 32'd3);
    chk("bp_out_valid", 32'(bus.out_valid), 32'd1);
    chk("bp_out_rd", 32'(bus.out_rd), 32'd9);
    chk("bp_in_ready_full", 32'(bus.in_ready), 32'd0);
    mark = n_out;
    bus.out_ready = 1'b1;
    #1;
    chk("bp_in_ready_drain", 32'(bus.in_ready), 32'd1);
    drain();
    chk("bp_count", 32'(n_out - mark), 32'd3);

    // Flush with two ops in flight and out_valid high
    bus.out_ready = 1'b0;
    push_op(32'd11, 32'd2, 4'd1, 32'd22);
    push_op(32'd12, 32'd2, 4'd2, 32'd24);
    push_op(32'd13, 32'd2, 4'd3, 32'd26);
    chk("fl_pre_out_valid", 32'(bus.out_valid), 32'd1);
    flush         = 1'b1;
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_a      = 32'd1;
    bus.in_b      = 32'd1;
    bus.in_rd     = 4'd8;
    #1;
    chk("fl_in_ready", 32'(bus.in_ready), 32'd0);
    @(posedge clk); #1;
    flush        = 1'b0;
    bus.in_valid = 1'b0;
    exp_q.delete();
    chk("fl_out_valid", 32'(bus.out_valid), 32'd0);
    chk("fl_busy", 32'(w_busy), 32'd0);
    push_op(32'd9, 32'hFFFFFFF7, 4'd6, 32'hFFFFFFAF);
    a0 = acc_cyc;
    drain();
    chk("fl_latency", 32'(last_out - a0), 32'd3);

    // Asynchronous reset with three ops in flight
    bus.out_ready = 1'b0;
    push_op(32'd4, 32'd4, 4'd1, 32'd16);
    push_op(32'd5, 32'd5, 4'd2, 32'd25);
    push_op(32'd6, 32'd6, 4'd3, 32'd36);
    chk("ar_pre_busy", 32'(w_busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_out_valid", 32'(bus.out_valid), 32'd0);
    chk("ar_busy", 32'(w_busy), 32'd0);
    chk("ar_out_result", bus.out_result, 32'd0);
    chk("ar_out_rd", 32'(bus.out_rd), 32'd0);
    exp_q.delete();
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("ar_in_ready", 32'(bus.in_ready), 32'd1);
    bus.out_ready = 1'b1;
    push_op(32'd6, 32'd7, 4'd2, 32'h0000002A);
    push_op(32'hFFFFFFFB, 32'd3, 4'd15, 32'hFFFFFFF1);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
